uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_byte_fetch.sv | 35 +++
 rtl/uart_cmd_parser.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and helpers for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam int unsigned MAX_LEN_DEF = 16;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// Pop/capture handshake towards the RX FIFO.
// Ports:
//   clk, rst       clock, async active-high reset
//   want           consumer will accept a byte at the end of the current cycle
//   rx_fifo_empty  FIFO holds no data
//   rx_byte        FIFO read data, valid the cycle after a pop
//   rx_fifo_pop    registered one-cycle pop pulse
//   byte_strobe    registered; high in the cycle the popped byte is on data_c
//   data_c         byte to capture while byte_strobe is high
module uart_byte_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       want,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_byte,
  output logic       rx_fifo_pop,
  output logic       byte_strobe,
  output logic [7:0] data_c
);

  assign data_c = rx_byte;

  // A pop is never issued in the cycle right after a pop, so at most one
  // byte is in flight and the FIFO sees one pop per two cycles at best.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_fifo_pop <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      rx_fifo_pop <= want && !rx_fifo_empty && !rx_fifo_pop;
      byte_strobe <= rx_fifo_pop;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed command parser: SYNC 0xA5, LEN, LEN payload bytes, CHK (XOR of LEN
// and payload). A good frame is held for the consumer until pkt_ack.
// Ports:
//   clk, rst                 clock, async active-high reset
//   rx_byte, rx_fifo_empty   RX FIFO read side
//   rx_fifo_pop              registered pop pulse
//   pkt_valid, pkt_len       held frame status and payload length
//   pkt_rd_addr/pkt_rd_data  combinational payload read port
//   pkt_ack                  consumer releases the held frame
//   chk_err_cnt, len_err_cnt, tmo_cnt  saturating error counters
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter  int unsigned MAX_LEN     = MAX_LEN_DEF,
  parameter  int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_fifo_empty,
  output logic             rx_fifo_pop,
  output logic             pkt_valid,
  output logic [7:0]       pkt_len,
  input  logic [AW-1:0]    pkt_rd_addr,
  output logic [7:0]       pkt_rd_data,
  input  logic             pkt_ack,
  output logic [CNT_W-1:0] chk_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] tmo_cnt
);

  state_t          state_q, state_d;
  logic [7:0]      len_q;
  logic [7:0]      xor_q;
  logic [AW-1:0]   idx_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      payload_q [MAX_LEN];

  logic            want_c;
  logic            byte_strobe;
  logic [7:0]      byte_c;
  logic            active_c;
  logic            tmo_hit_c;
  logic            load_len_c;
  logic            wr_data_c;
  logic            len_err_c;
  logic            chk_err_c;
  logic            tmo_err_c;

  // Fetch is driven from the next state so a new pop can start in the same
  // edge that consumes the previous byte.
  assign want_c = (state_d != ST_HOLD);

  uart_byte_fetch u_fetch (
    .clk           (clk),
    .rst           (rst),
    .want          (want_c),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_byte       (rx_byte),
    .rx_fifo_pop   (rx_fifo_pop),
    .byte_strobe   (byte_strobe),
    .data_c        (byte_c)
  );

  // Gap timer only runs mid-frame; a captured byte wins over expiry.
  assign active_c  = state_q inside {ST_LEN, ST_DATA, ST_CHK};
  assign tmo_hit_c = active_c && !byte_strobe && (tmo_q == TW'(TIMEOUT_CYC - 1));

  // Next-state and per-byte actions.
  always_comb begin
    state_d    = state_q;
    load_len_c = 1'b0;
    wr_data_c  = 1'b0;
    len_err_c  = 1'b0;
    chk_err_c  = 1'b0;
    tmo_err_c  = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (byte_strobe && byte_c == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (byte_strobe) begin
          if (byte_c == 8'h00 || 32'(byte_c) > MAX_LEN) begin
            len_err_c = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            load_len_c = 1'b1;
            state_d    = ST_DATA;
          end
        end else if (tmo_hit_c) begin
          tmo_err_c = 1'b1;
          state_d   = ST_HUNT;
        end
      end
      ST_DATA: begin
        if (byte_strobe) begin
          wr_data_c = 1'b1;
          if (idx_q == AW'(len_q - 8'd1)) state_d = ST_CHK;
        end else if (tmo_hit_c) begin
          tmo_err_c = 1'b1;
          state_d   = ST_HUNT;
        end
      end
      ST_CHK: begin
        if (byte_strobe) begin
          if (byte_c == xor_q) begin
            state_d = ST_HOLD;
          end else begin
            chk_err_c = 1'b1;
            state_d   = ST_HUNT;
          end
        end else if (tmo_hit_c) begin
          tmo_err_c = 1'b1;
          state_d   = ST_HUNT;
        end
      end
      ST_HOLD: begin
        if (pkt_ack) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // State, frame bookkeeping and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      pkt_valid   <= 1'b0;
      pkt_len     <= 8'h00;
      len_q       <= 8'h00;
      xor_q       <= 8'h00;
      idx_q       <= '0;
      tmo_q       <= '0;
      chk_err_cnt <= '0;
      len_err_cnt <= '0;
      tmo_cnt     <= '0;
    end else begin
      state_q   <= state_d;
      pkt_valid <= (state_d == ST_HOLD);
      if (state_q == ST_CHK && state_d == ST_HOLD) pkt_len <= len_q;
      if (load_len_c) begin
        len_q <= byte_c;
        xor_q <= byte_c;
        idx_q <= '0;
      end else if (wr_data_c) begin
        xor_q <= xor_q ^ byte_c;
        idx_q <= idx_q + AW'(1);
      end
      if (!active_c || byte_strobe || tmo_hit_c) tmo_q <= '0;
      else                                      tmo_q <= tmo_q + TW'(1);
      if (chk_err_c) chk_err_cnt <= sat_inc(chk_err_cnt);
      if (len_err_c) len_err_cnt <= sat_inc(len_err_cnt);
      if (tmo_err_c) tmo_cnt     <= sat_inc(tmo_cnt);
    end
  end

  // Payload storage; contents are don't-care outside a held frame.
  always_ff @(posedge clk) begin
    if (wr_data_c) payload_q[idx_q] <= byte_c;
  end

  assign pkt_rd_data = (32'(pkt_rd_addr) < MAX_LEN) ? payload_q[pkt_rd_addr] : 8'h00;

endmodule
